// File: rtl/jk_ctrl_pkg.sv
// Shared encodings for the JK bank controller: command opcodes and FSM states.
package jk_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_CLEAR  = 3'b001,
    OP_SET    = 3'b010,
    OP_TOGGLE = 3'b011,
    OP_LOAD   = 3'b100,
    OP_UP     = 3'b101,
    OP_DOWN   = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_APPLY = 3'd2,
    ST_COUNT = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops driven by the controller; used for integration and test.
module jk_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ff
    jk_ff u_ff (
      .clock (clock),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i])
    );
  end

endmodule

// File: rtl/jk_ff.sv
// Plain JK flip-flop: 00 hold, 01 reset, 10 set, 11 toggle.
// No reset of its own; the controller clears it by driving K during reset/INIT.
module jk_ff (
  input  logic clock,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK next-state behaviour
  always_ff @(posedge clock) begin
    case ({j, k})
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      2'b11:   q <= ~q;
      default: q <= q;
    endcase
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven controller for a bank of JK flip-flops.
//
// state | meaning
// INIT  | one cycle after reset, bank forced to zero through K
// IDLE  | bank held, command accepted
// APPLY | one-cycle clear/set/toggle/load drive
// COUNT | one binary step per cycle for N cycles
// RESP  | done pulse with err/ovf, bank held
//
// J/K drives and handshake/response flags are decoded combinationally from the
// state, the latched command and q_in, because count steps depend on the
// current bank value in the same cycle.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             done,
  output logic             err,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rem_q;
  logic             wrap_q;
  logic [WIDTH-1:0] step_mask;
  logic             carry;
  logic             cnt_wrap;

  assign cmd_ready = (state == ST_IDLE);
  assign done      = (state == ST_RESP);
  assign err       = done && (op_q == OP_RSVD);
  assign ovf       = done && wrap_q;
  assign cnt_wrap  = (op_q == OP_UP) ? (q_in == ONES) : (q_in == '0);

  // Ripple-carry toggle mask: bit i toggles when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    step_mask = '0;
    carry     = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step_mask[i] = carry;
      carry        = carry & ((op_q == OP_DOWN) ? ~q_in[i] : q_in[i]);
    end
  end

  // J/K drive decode per state and latched opcode
  always_comb begin
    j_out = '0;
    k_out = '0;
    case (state)
      ST_INIT: k_out = ONES;
      ST_APPLY: begin
        case (op_q)
          OP_CLEAR:  k_out = ONES;
          OP_SET:    j_out = ONES;
          OP_TOGGLE: begin
            j_out = data_q;
            k_out = data_q;
          end
          OP_LOAD: begin
            j_out = data_q;
            k_out = ~data_q;
          end
          default: ;
        endcase
      end
      ST_COUNT: begin
        j_out = step_mask;
        k_out = step_mask;
      end
      default: ;
    endcase
  end

  // Sequencing FSM with command latch, step counter and wrap flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_INIT;
      op_q   <= OP_NOP;
      data_q <= '0;
      rem_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: state <= ST_IDLE;
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q   <= op_e'(cmd_op);
            data_q <= cmd_data;
            rem_q  <= cmd_data;
            wrap_q <= 1'b0;
            case (op_e'(cmd_op))
              OP_UP, OP_DOWN: state <= (cmd_data != '0) ? ST_COUNT : ST_RESP;
              OP_CLEAR, OP_SET, OP_TOGGLE, OP_LOAD: state <= ST_APPLY;
              default: state <= ST_RESP;
            endcase
          end
        end
        ST_APPLY: state <= ST_RESP;
        ST_COUNT: begin
          rem_q <= rem_q - ONE;
          if (cnt_wrap) wrap_q <= 1'b1;
          if (rem_q == ONE) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl driving a 4-bit jk_bank. Expected responses are queued
// at issue time and checked by an independent monitor whenever done is seen.
module tb_jk_bank_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] q_in;
  logic [3:0] j_out;
  logic [3:0] k_out;
  logic       done;
  logic       err;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] q;
    logic       err;
    logic       ovf;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  jk_bank_ctrl #(.WIDTH(4)) u_dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .q_in      (q_in),
    .j_out     (j_out),
    .k_out     (k_out),
    .done      (done),
    .err       (err),
    .ovf       (ovf)
  );

  jk_bank #(.WIDTH(4)) u_bank (
    .clock (clock),
    .j     (j_out),
    .k     (k_out),
    .q     (q_in)
  );

  always #5 clock = ~clock;

  // cyc holds the index of the most recent rising edge
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; waits for IDLE, offers the command, queues the expectation.
  // lat counts cycles from the accept edge to the edge that closes the done cycle.
  task automatic issue(input logic [2:0] op, input logic [3:0] data, input logic [3:0] eq,
                       input logic ee, input logic eo, input int lat, input bit push,
                       input bit hold);
    int n = 0;
    exp_t x;
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: cmd_ready stayed 0 for op %0b", op);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    if (push) begin
      x.q = eq; x.err = ee; x.ovf = eo; x.lat = lat; x.acc = cyc + 1;
      sb.push_back(x);
    end
    if (!hold) begin
      @(negedge clock);
      cmd_valid = 1'b0;
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  initial begin
    forever begin
      @(negedge clock);
      if (resetn === 1'b1 && done === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: done=1 with nothing outstanding (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("done_q",   32'(q_in), 32'(e.q));
          chk("done_err", 32'(err),  32'(e.err));
          chk("done_ovf", 32'(ovf),  32'(e.ovf));
          chk("done_lat", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  logic [3:0] up_seq [3];
  int         extra;
  bit         seen;

  initial begin
    up_seq[0] = 4'b1111;
    up_seq[1] = 4'b0000;
    up_seq[2] = 4'b0001;
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = 4'b0000;

    // Reset and release
    repeat (3) @(negedge clock);
    chk("rst_k",     32'(k_out),     32'hF);
    chk("rst_j",     32'(j_out),     32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h0);
    chk("rst_done",  32'({done, err, ovf}), 32'h0);
    resetn = 1'b1;
    #1;
    chk("init_ready", 32'(cmd_ready), 32'h0);
    chk("init_k",     32'(k_out),     32'hF);
    @(negedge clock);
    chk("idle_ready", 32'(cmd_ready), 32'h1);
    chk("idle_q",     32'(q_in),      32'h0);
    chk("idle_jk",    32'({j_out, k_out}), 32'h0);

    // Single-cycle ops
    issue(3'b100, 4'b1010, 4'b1010, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    issue(3'b011, 4'b0110, 4'b1100, 1'b0, 1'b0, 2, 1'b1, 1'b0);

    // Count up through wrap, with per-step bank checks
    issue(3'b100, 4'b1110, 4'b1110, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    issue(3'b101, 4'd3,    4'b0001, 1'b0, 1'b1, 4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("up_step%0d", i), 32'(q_in), 32'(up_seq[i]));
    end

    // Zero-length count and reserved opcode
    issue(3'b100, 4'b0101, 4'b0101, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    issue(3'b110, 4'd0,    4'b0101, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    issue(3'b111, 4'b1111, 4'b0101, 1'b1, 1'b0, 1, 1'b1, 1'b0);

    // SET, CLEAR, NOP, count down through wrap
    issue(3'b010, 4'b0000, 4'b1111, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    issue(3'b001, 4'b1111, 4'b0000, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    issue(3'b000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    issue(3'b110, 4'd2,    4'b1110, 1'b0, 1'b1, 3, 1'b1, 1'b0);

    // cmd_valid held high through a 5-step count: only one accept
    issue(3'b101, 4'd5, 4'b0011, 1'b0, 1'b1, 6, 1'b1, 1'b1);
    extra = 0;
    seen  = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
      else if (cmd_ready) extra++;
    end
    cmd_valid = 1'b0;
    chk("held_done_seen", 32'(seen),  32'h1);
    chk("held_extra_acc", 32'(extra), 32'h0);

    // Reset in the middle of a long count: command abandoned, bank cleared
    issue(3'b101, 4'd10, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("midrst_k",     32'(k_out),     32'hF);
    chk("midrst_j",     32'(j_out),     32'h0);
    chk("midrst_ready", 32'(cmd_ready), 32'h0);
    chk("midrst_flags", 32'({done, err, ovf}), 32'h0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("midrst_init_ready", 32'(cmd_ready), 32'h0);
    @(negedge clock);
    chk("midrst_q",     32'(q_in),      32'h0);
    chk("midrst_ready2", 32'(cmd_ready), 32'h1);

    // Normal operation resumes, wrap flag from before does not leak
    issue(3'b100, 4'b0011, 4'b0011, 1'b0, 1'b0, 2, 1'b1, 1'b0);

    repeat (6) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jk_bank_ctrl.md
JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of JK flip-flops in the controlled bank.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high at a clock edge.
REQ-006 SHALL have port cmd_op, input, 3 bits: opcode, 000 NOP, 001 CLEAR, 010 SET, 011 TOGGLE, 100 LOAD, 101 COUNT_UP, 110 COUNT_DOWN, 111 reserved.
REQ-007 SHALL have port cmd_data, input, WIDTH bits: toggle mask, load value, or step count N.
REQ-008 SHALL have port q_in, input, WIDTH bits: Q outputs of the bank.
REQ-009 SHALL have ports j_out and k_out, outputs, WIDTH bits each: J and K drives to the bank.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1 bit: valid only with done; reserved opcode.
REQ-012 SHALL have port ovf, output, 1 bit: valid only with done; a count wrapped.

Function
REQ-013 SHALL implement states INIT, IDLE, APPLY, COUNT and RESP.
- States are registered.
- j_out, k_out, cmd_ready, done, err and ovf are decoded from the state, the latched command and q_in.
REQ-014 INIT SHALL:
- drive j_out=0 and k_out=all-ones (clear bank);
- hold cmd_ready=0;
- last exactly one cycle after reset release, then go to IDLE.
REQ-015 IDLE SHALL:
- drive j_out=k_out=0 (hold);
- hold cmd_ready=1;
- on accept, latch op and data.
REQ-016 On accept the next state SHALL be:
- COUNT for COUNT_UP or COUNT_DOWN with N>0;
- RESP for NOP, reserved opcode, or count with N=0;
- APPLY otherwise.
REQ-017 APPLY SHALL last one cycle, then go to RESP, driving:
- CLEAR: J=0, K=all-ones;
- SET: J=all-ones, K=0;
- TOGGLE: J=K=mask;
- LOAD: J=data, K=~data.
REQ-018 COUNT SHALL drive one binary step per cycle:
- up: J[i]=K[i]=AND of q_in[i-1:0];
- down: J[i]=K[i]=AND of ~q_in[i-1:0];
- bit 0 always toggles.
REQ-019 COUNT SHALL decrement a remaining-steps register each cycle and leave for RESP after exactly N cycles.
REQ-020 COUNT SHALL set an internal wrap flag in any cycle where up and q_in=all-ones, or down and q_in=0; the flag is cleared on accept.
REQ-021 RESP SHALL:
- drive j_out=k_out=0 and cmd_ready=0;
- assert done for one cycle;
- assert err if op=111;
- assert ovf if the wrap flag is set;
- then go to IDLE.
REQ-022 Latency SHALL be fixed:
- single ops: accept at edge t, bank updated at edge t+1, done high in cycle t+2 with q_in already updated;
- counts: done N+1 cycles after accept.
REQ-023 A reserved opcode SHALL leave the bank unchanged.
REQ-024 cmd_ready SHALL be low in every state except IDLE; cmd_valid outside IDLE is ignored.

Reset
REQ-025 resetn low SHALL immediately force:
- state INIT, cmd_ready=0, done=0, err=0, ovf=0;
- j_out=0, k_out=all-ones;
- wrap flag and remaining-steps register cleared.
REQ-026 Reset mid-command SHALL abandon the command with no done pulse, and the bank SHALL read 0 after INIT.

Structure
REQ-027 Opcode and state encodings SHALL live in a shared package jk_ctrl_pkg.
REQ-028 The controller SHALL be flat.
REQ-029 A companion sub-module jk_bank SHALL instantiate WIDTH existing JK flip-flops for integration and test.

Verification (WIDTH=4, controller driving jk_bank)
REQ-030 Reset then release: k_out=1111 during reset; one INIT cycle; q_in=0000; cmd_ready=1 in the second cycle after release.
REQ-031 LOAD 1010: done in cycle t+2 with q_in=1010. Then TOGGLE 0110: q_in=1100, err=0, ovf=0.
REQ-032 LOAD 1110, then COUNT_UP N=3: q_in steps 1111, 0000, 0001; done 4 cycles after accept with ovf=1.
REQ-033 COUNT_DOWN N=0 from 0101: done in cycle t+1, q_in=0101, ovf=0. Then op 111: done with err=1, q_in unchanged.
REQ-034 cmd_valid held high during COUNT_UP N=5: no second accept until IDLE; exactly one done.
REQ-035 resetn low mid COUNT_UP N=10: no done; after release q_in=0000 and cmd_ready returns high.
